ps2_key_tracker: RTL and testbench

Consumes the 11-bit `key_event` word from the PS/2 keyboard receiver and turns it into per-key state for the VGA game logic. It does four things:
- brings the receiver's PS/2-clock-derived output into the `clk_100mhz` domain;
- decodes eight game keys into a held bitmap with one-cycle press and release pulses;
- queues every received event in a small ready/valid FIFO for text or debug consumers;
- sits directly downstream of the keyboard receiver and upstream of the game and display control.

---
 rtl/ps2_key_tracker.sv | 147 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 key event tracker: synchronizes the receiver's event strobe, decodes eight game keys
// and queues every event in a FWFT FIFO. Optional build macro: PS2_TYPEMATIC_FILTER_EN.
module ps2_key_tracker #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic [10:0] key_event,
  output logic [7:0]  key_held,
  output logic [7:0]  key_press,
  output logic [7:0]  key_release,
  output logic        ev_valid,
  output logic [9:0]  ev_data,
  input  logic        ev_ready,
  output logic        ev_drop
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [9:0]             cap_q;
  logic                   upd_q;

  logic [7:0] held_q, press_q, release_q;
  logic       hit;
  logic [2:0] idx;
  logic [7:0] onehot;
  logic       held_hit;
  logic       repeat_make;
  logic       push;

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [9:0]  last_q;
  logic        drop_q;
  logic        full, empty, pop, wr_en;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Only the strobe is synchronized; the payload bits are stable while it is high.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_event[10]};
      prev_q <= sync_q[SYNC_STAGES-1];
      upd_q  <= rise;
      if (rise) begin
        cap_q <= key_event[9:0];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    case ({cap_q[9], cap_q[7:0]})
      9'h01D: begin hit = 1'b1; idx = 3'd0; end
      9'h01C: begin hit = 1'b1; idx = 3'd1; end
      9'h01B: begin hit = 1'b1; idx = 3'd2; end
      9'h023: begin hit = 1'b1; idx = 3'd3; end
      9'h175: begin hit = 1'b1; idx = 3'd4; end
      9'h16B: begin hit = 1'b1; idx = 3'd5; end
      9'h172: begin hit = 1'b1; idx = 3'd6; end
      9'h174: begin hit = 1'b1; idx = 3'd7; end
      default: begin hit = 1'b0; idx = 3'd0; end
    endcase
    onehot   = 8'b1 << idx;
    held_hit = held_q[idx];
`ifdef PS2_TYPEMATIC_FILTER_EN
    repeat_make = hit & ~cap_q[8] & held_hit;
`else
    repeat_make = 1'b0;
`endif
    push = upd_q & ~repeat_make;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      if (upd_q && hit) begin
        if (!cap_q[8]) begin
          held_q <= held_q | onehot;
          if (!repeat_make) begin
            press_q <= onehot;
          end
        end else if (held_hit) begin
          held_q    <= held_q & ~onehot;
          release_q <= onehot;
        end
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  // At full, a same-cycle pop frees the slot being written.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_100mhz) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= cap_q;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
      drop_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
      if (!empty) begin
        last_q <= mem_q[rptr_q[AW-1:0]];
      end
      if (push && full && !pop) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign ev_valid    = ~empty;
  assign ev_data     = empty ? last_q : mem_q[rptr_q[AW-1:0]];
  assign ev_drop     = drop_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized bench for ps2_key_tracker against a queue-based reference model.
// Honours PS2_TYPEMATIC_FILTER_EN the same way as the design build.
module tb_ps2_key_tracker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SS    = 2;
  localparam logic [8:0] KEY_TAB [8] = '{9'h01D, 9'h01C, 9'h01B, 9'h023,
                                         9'h175, 9'h16B, 9'h172, 9'h174};

  logic        clk_100mhz = 1'b0;
  logic        rst_n;
  logic [10:0] key_event;
  logic [7:0]  key_held, key_press, key_release;
  logic        ev_valid, ev_ready, ev_drop;
  logic [9:0]  ev_data;

  always #5 clk_100mhz = ~clk_100mhz;

  ps2_key_tracker #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .key_event  (key_event),
    .key_held   (key_held),
    .key_press  (key_press),
    .key_release(key_release),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_ready   (ev_ready),
    .ev_drop    (ev_drop)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q [$];
  logic [7:0] m_held, m_press, m_release;
  logic [9:0] m_last, m_pending;
  bit         m_drop;
  int         upd_cnt;
  bit         rand_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [9:0] ev);
    for (int k = 0; k < 8; k++) begin
      if (KEY_TAB[k] == {ev[9], ev[7:0]}) return k;
    end
    return -1;
  endfunction

  task automatic apply_event(input logic [9:0] ev, output bit push);
    int k;
    k = key_index(ev);
    push = 1'b1;
    if (k >= 0) begin
      if (!ev[8]) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (m_held[k]) push = 1'b0;
        else m_press[k] = 1'b1;
`else
        m_press[k] = 1'b1;
`endif
        m_held[k] = 1'b1;
      end else if (m_held[k]) begin
        m_held[k]    = 1'b0;
        m_release[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check_eq("key_held", 32'(key_held), 32'(m_held));
    check_eq("key_press", 32'(key_press), 32'(m_press));
    check_eq("key_release", 32'(key_release), 32'(m_release));
    check_eq("ev_valid", 32'(ev_valid), 32'(exp_q.size() > 0));
    check_eq("ev_data", 32'(ev_data), 32'((exp_q.size() > 0) ? exp_q[0] : m_last));
    check_eq("ev_drop", 32'(ev_drop), 32'(m_drop));
  endtask

  // One clock: model the edge, then compare on the falling edge.
  task automatic step();
    bit do_pop, push;
    int sz;
    if (rand_rdy) ev_ready = 1'($urandom_range(0, 1));
    sz     = exp_q.size();
    do_pop = ev_ready && (sz > 0);
    push   = 1'b0;
    @(posedge clk_100mhz);
    m_press   = '0;
    m_release = '0;
    if (upd_cnt > 0) begin
      upd_cnt--;
      if (upd_cnt == 0) apply_event(m_pending, push);
    end
    if (do_pop) begin
      m_last = exp_q[0];
      void'(exp_q.pop_front());
    end
    if (push) begin
      if (sz < DEPTH || do_pop) exp_q.push_back(m_pending);
      else m_drop = 1'b1;
    end
    @(negedge clk_100mhz);
    check_all();
  endtask

  task automatic send_ev(input logic [9:0] ev, input int hold, input bit pop_at_upd);
    key_event = {1'b1, ev};
    m_pending = ev;
    upd_cnt   = SS + 2;
    for (int i = 0; i < hold + 8; i++) begin
      if (i == hold) key_event = {1'b0, ev};
      if (pop_at_upd) ev_ready = (upd_cnt == 1);
      step();
    end
    if (pop_at_upd) ev_ready = 1'b0;
  endtask

  task automatic do_reset(input logic [10:0] ke_at_release);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_key_held", 32'(key_held), 32'h0);
    check_eq("rst_key_press", 32'(key_press), 32'h0);
    check_eq("rst_key_release", 32'(key_release), 32'h0);
    check_eq("rst_ev_valid", 32'(ev_valid), 32'h0);
    check_eq("rst_ev_data", 32'(ev_data), 32'h0);
    check_eq("rst_ev_drop", 32'(ev_drop), 32'h0);
    exp_q.delete();
    m_held = '0; m_press = '0; m_release = '0;
    m_last = '0; m_drop = 1'b0; upd_cnt = 0;
    ev_ready  = 1'b0;
    key_event = ke_at_release;
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    if (ke_at_release[10]) begin
      m_pending = ke_at_release[9:0];
      upd_cnt   = SS + 2;
      repeat (10) step();
      key_event[10] = 1'b0;
      repeat (6) step();
    end else begin
      repeat (3) step();
    end
  endtask

  task automatic drain(input int cycles);
    ev_ready = 1'b1;
    repeat (cycles) step();
    ev_ready = 1'b0;
  endtask

  initial begin
    logic [9:0] ev;
    int         k;
    rst_n     = 1'b1;
    key_event = '0;
    ev_ready  = 1'b0;
    rand_rdy  = 1'b0;
    @(negedge clk_100mhz);
    do_reset(11'h000);

    send_ev(10'h01D, 50, 1'b0);          // W held for 50 cycles
    send_ev(10'h275, 5, 1'b0);           // Up make
    send_ev(10'h375, 5, 1'b0);           // Up break
    repeat (3) send_ev(10'h01C, 3, 1'b0); // A auto-repeat
    drain(12);
    send_ev(10'h075, 2, 1'b0);           // keypad 8, unmapped
    send_ev(10'h11B, 2, 1'b0);           // break of a key not held
    send_ev(10'h11D, 1, 1'b0);           // W release
    drain(6);

    do_reset(11'h000);                   // overflow
    for (int i = 0; i < 9; i++) send_ev(10'h016, 2, 1'b0);
    drain(12);

    do_reset(11'h000);                   // push and pop together at full
    for (int i = 0; i < 8; i++) send_ev(10'(10'h010 + i), 2, 1'b0);
    send_ev(10'h0AA, 2, 1'b1);
    drain(12);

    rand_rdy = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        k  = int'($urandom_range(0, 7));
        ev = {KEY_TAB[k][8], 1'($urandom_range(0, 1)), KEY_TAB[k][7:0]};
      end else begin
        ev = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom)};
      end
      send_ev(ev, int'($urandom_range(1, 6)), 1'b0);
    end
    rand_rdy = 1'b0;

    do_reset(11'h000);                   // reset while W and D are held
    send_ev(10'h01D, 2, 1'b0);
    send_ev(10'h023, 2, 1'b0);
    check_eq("held_wd", 32'(key_held), 32'h09);
    do_reset(11'h000);
    repeat (8) step();

    do_reset({1'b1, 10'h01B});           // strobe high across reset release

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
